// File: rtl/dw3_11_gen.sv
// dw3_11_gen: batch gradient accumulator for the w3_11 weight.
// Each accepted sample contributes delta3_1 * a2_1 (Q6.10 x Q6.10 -> Q12.20,
// rescaled to Q6.10) to a running sum. After BATCH samples the block emits
// dw3_11 = sat16(-(sum >>> LR_SHIFT)) with a one-cycle select_update pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a sample; operands are captured when sample_valid=1
// MUL   | form the full 32-bit signed product of the captured operands
// ACC   | add the rescaled product into the accumulator; emit on last sample
module dw3_11_gen #(
   parameter int BATCH    = 4,
   parameter int LR_SHIFT = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               sample_valid,
   output logic               sample_ready,
   input  logic signed [15:0] delta3_1,
   input  logic signed [15:0] a2_1,
   output logic signed [15:0] dw3_11,
   output logic               select_update
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;

   localparam logic [4:0] LAST_CNT = 5'(BATCH - 1);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic signed [15:0] delta_q;
   logic signed [15:0] a2_q;
   logic signed [31:0] prod;
   logic signed [23:0] acc;
   logic [4:0]         cnt;

   logic signed [23:0] prod_term;
   logic signed [23:0] acc_sum;
   logic signed [23:0] acc_shr;
   logic signed [24:0] neg_val;
   logic signed [15:0] dw_sat;
   logic               last_sample;

   // Moore handshake: a sample can only be taken while waiting in IDLE.
   assign sample_ready = (state == IDLE);

   // The accumulate step is the one that closes a batch when the counter has
   // already seen BATCH-1 samples.
   assign last_sample = (state == ACC) && (cnt == LAST_CNT);

   // Product rescaled from Q12.20 to Q6.10; arithmetic shift floors toward
   // minus infinity. The shifted value fits in 22 bits, so 24 bits hold it.
   assign prod_term = 24'(prod >>> 10);

   // Accumulator datapath and output scaling. The negation is done one bit
   // wider than the accumulator so that negating the most negative value
   // cannot wrap before the clamp.
   always_comb begin
      acc_sum = acc + prod_term;
      acc_shr = acc_sum >>> LR_SHIFT;
      neg_val = 25'sd0 - 25'(acc_shr);
      if (neg_val > 25'sd32767) begin
         dw_sat = 16'sh7FFF;
      end else if (neg_val < -25'sd32768) begin
         dw_sat = -16'sh8000;
      end else begin
         dw_sat = neg_val[15:0];
      end
   end

   // Next-state logic; clear returns to IDLE from any state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_valid) state_nxt = MUL;
         MUL:     state_nxt = ACC;
         ACC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clear) begin
         state_nxt = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture on acceptance; a sample offered with clear is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         delta_q <= '0;
         a2_q    <= '0;
      end else if ((state == IDLE) && sample_valid && !clear) begin
         delta_q <= delta3_1;
         a2_q    <= a2_1;
      end
   end

   // Full-precision signed product of the captured operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod <= '0;
      end else if ((state == MUL) && !clear) begin
         prod <= 32'(delta_q) * 32'(a2_q);
      end
   end

   // Batch accumulator and sample counter; both restart on clear or at the
   // end of every batch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (state == ACC) begin
         if (last_sample) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_sum;
            cnt <= cnt + 5'd1;
         end
      end
   end

   // Output register: dw3_11 only changes on a batch close, select_update
   // is high for exactly the cycle after that edge. clear suppresses both.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dw3_11        <= '0;
         select_update <= 1'b0;
      end else begin
         select_update <= 1'b0;
         if (last_sample && !clear) begin
            dw3_11        <= dw_sat;
            select_update <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dw3_11_gen.sv
// Directed bench for dw3_11_gen with a scoreboard of expected dw3_11 values.
module tb_dw3_11_gen;

   localparam int BATCH = 4;
   localparam int LR    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] delta3_1;
   logic [15:0] a2_1;
   logic [15:0] dw3_11;
   logic        select_update;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   longint      m_acc;
   int          m_cnt;
   logic [15:0] m_last_dw;
   int          pulses = 0;
   time         last_accept_t = 0;
   time         prev_acc_t = 0;
   time         last_pulse_t = 0;
   bit          cont_mode = 0;
   bit          prev_sel = 0;
   int          p0;

   dw3_11_gen #(.BATCH(BATCH), .LR_SHIFT(LR)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .delta3_1     (delta3_1),
      .a2_1         (a2_1),
      .dw3_11       (dw3_11),
      .select_update(select_update)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_dw(input longint acc);
      longint v;
      v = -(acc >>> LR);
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      return v[15:0];
   endfunction

   task automatic model_accept(input logic [15:0] d, input logic [15:0] a);
      longint p;
      p = longint'($signed(d)) * longint'($signed(a));
      m_acc += (p >>> 10);
      m_cnt++;
      if (m_cnt == BATCH) begin
         exp_q.push_back(model_dw(m_acc));
         m_acc = 0;
         m_cnt = 0;
      end
   endtask

   task automatic model_flush();
      m_acc = 0;
      m_cnt = 0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   // with sample_valid still high.
   task automatic send(input logic [15:0] d, input logic [15:0] a);
      int n;
      delta3_1     = d;
      a2_1         = a;
      sample_valid = 1'b1;
      n = 0;
      while (sample_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) check("ready_timeout", {31'b0, sample_ready}, 32'd1);
      @(posedge clk);
      model_accept(d, a);
      last_accept_t = $time;
      if (cont_mode && prev_acc_t != 0) check("accept_spacing", 32'($time - prev_acc_t), 32'd30);
      prev_acc_t = $time;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   task automatic batch(input logic [15:0] d, input logic [15:0] a, input int n);
      for (int i = 0; i < n; i++) send(d, a);
      sample_valid = 1'b0;
      drain();
      @(negedge clk);
   endtask

   // Scoreboard consumer and pulse-shape checks.
   always @(negedge clk) begin
      if (reset) begin
         prev_sel = 1'b0;
      end else begin
         if (select_update) begin
            check("pulse_single", {31'b0, prev_sel}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {31'b0, select_update}, 32'd0);
            end else begin
               m_last_dw = exp_q.pop_front();
               check("dw3_11", {16'b0, dw3_11}, {16'b0, m_last_dw});
            end
            check("pulse_latency", 32'($time - last_accept_t), 32'd25);
            check("ready_at_pulse", {31'b0, sample_ready}, 32'd1);
            if (cont_mode && last_pulse_t != 0) check("pulse_period", 32'($time - last_pulse_t), 32'd120);
            last_pulse_t = $time;
            pulses++;
         end
         prev_sel = select_update;
      end
   end

   initial begin
      reset        = 1'b1;
      clear        = 1'b0;
      sample_valid = 1'b0;
      delta3_1     = '0;
      a2_1         = '0;
      m_acc        = 0;
      m_cnt        = 0;
      m_last_dw    = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'b0, sample_ready}, 32'd1);
      check("rst_dw", {16'b0, dw3_11}, 32'h0);
      check("rst_sel", {31'b0, select_update}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic batch: 1.0 * 0.5 four times -> -0.25
      p0 = pulses;
      batch(16'h0400, 16'h0200, 4);
      check("basic_pulses", pulses - p0, 32'd1);
      check("basic_dw", {16'b0, dw3_11}, 32'h0000FF00);

      // Large products saturate negative without accumulator wrap
      p0 = pulses;
      batch(16'h7FFF, 16'h7FFF, 4);
      check("sat_pulses", pulses - p0, 32'd1);
      check("sat_dw", {16'b0, dw3_11}, 32'h00008000);

      // Floor truncation of a tiny negative product
      p0 = pulses;
      batch(16'hFFFF, 16'h0001, 4);
      check("floor_pulses", pulses - p0, 32'd1);
      check("floor_dw", {16'b0, dw3_11}, 32'h00000001);

      // Reset in the middle of a batch
      send(16'h0400, 16'h0200);
      send(16'h0400, 16'h0200);
      sample_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_dw", {16'b0, dw3_11}, 32'h0);
      check("midrst_sel", {31'b0, select_update}, 32'd0);
      check("midrst_ready", {31'b0, sample_ready}, 32'd1);
      model_flush();
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      p0 = pulses;
      batch(16'h0400, 16'h0200, 4);
      check("postrst_pulses", pulses - p0, 32'd1);
      check("postrst_dw", {16'b0, dw3_11}, 32'h0000FF00);

      // Random operands, two batches, values from the model
      p0 = pulses;
      for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom));
      sample_valid = 1'b0;
      drain();
      @(negedge clk);
      check("rand_pulses", pulses - p0, 32'd2);

      // Clear in IDLE together with an offered sample
      send(16'h7FFF, 16'h7FFF);
      send(16'h7FFF, 16'h7FFF);
      send(16'h7FFF, 16'h7FFF);
      sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      clear        = 1'b1;
      sample_valid = 1'b1;
      delta3_1     = 16'h7FFF;
      a2_1         = 16'h7FFF;
      @(negedge clk);
      clear        = 1'b0;
      sample_valid = 1'b0;
      model_flush();
      check("clr_ready", {31'b0, sample_ready}, 32'd1);
      check("clr_dw_kept", {16'b0, dw3_11}, {16'b0, m_last_dw});
      check("clr_sel", {31'b0, select_update}, 32'd0);
      @(negedge clk);
      check("clr_sample_dropped", {31'b0, sample_ready}, 32'd1);
      p0 = pulses;
      batch(16'h0400, 16'h0200, 4);
      check("postclr_pulses", pulses - p0, 32'd1);
      check("postclr_dw", {16'b0, dw3_11}, 32'h0000FF00);

      // Clear while a sample is in MUL discards it
      send(16'h7FFF, 16'h7FFF);
      sample_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_flush();
      check("clrmul_ready", {31'b0, sample_ready}, 32'd1);
      check("clrmul_sel", {31'b0, select_update}, 32'd0);
      p0 = pulses;
      batch(16'hFFFF, 16'h0001, 4);
      check("clrmul_pulses", pulses - p0, 32'd1);
      check("clrmul_dw", {16'b0, dw3_11}, 32'h00000001);

      // Continuous sample_valid: accept every 3 cycles, pulse every 12
      cont_mode    = 1'b1;
      prev_acc_t   = 0;
      last_pulse_t = 0;
      p0 = pulses;
      for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom));
      sample_valid = 1'b0;
      drain();
      @(negedge clk);
      cont_mode = 1'b0;
      check("cont_pulses", pulses - p0, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
